i2s_tx: RTL and testbench

- I2S master transmitter: the transmit-side counterpart of the codebase's I2S receiver, for driving an external DAC with processed or pass-through audio.
- Derives bck and lrck from clk and serialises one stereo pair of WIDTH-bit two's-complement samples per frame, MSB first, standard I2S (Philips) format.
- Accepts sample pairs from the datapath through a valid/ready handshake, with a one-pair holding buffer.

---
 rtl/i2s_pkg.sv | 17 +
 rtl/i2s_clkgen.sv | 72 +++++++
 rtl/i2s_tx.sv | 117 +++++++++++
 tb/tb_i2s_tx.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// i2s_pkg: shared I2S definitions for the transmit and receive sides.
//   SLOT_DEF    : default bck periods per channel slot
//   WIDTH_DEF   : default sample width per channel
//   BCK_DIV_DEF : default clk cycles per bck period
//   stereo_t    : one left/right sample pair at the default width
package i2s_pkg;

  localparam int unsigned SLOT_DEF    = 32;
  localparam int unsigned WIDTH_DEF   = 24;
  localparam int unsigned BCK_DIV_DEF = 4;

  typedef struct packed {
    logic [WIDTH_DEF-1:0] left;
    logic [WIDTH_DEF-1:0] right;
  } stereo_t;

endpackage

// File: rtl/i2s_clkgen.sv
// i2s_clkgen: bit clock / word select generator for the I2S master.
//   clk, reset     : system clock, synchronous active-low reset
//   o_bck          : registered bit clock, high while div_cnt >= BCK_DIV/2
//   o_lrck         : registered word select, 1 while bit_cnt >= SLOT
//   o_fall         : the coming clk edge is a falling bck edge
//   o_frame_wrap   : the coming falling edge wraps bit_cnt 2*SLOT-1 -> 0
//   o_bit_nxt      : bit_cnt value after the coming clk edge
module i2s_clkgen
  import i2s_pkg::*;
#(
  parameter int unsigned SLOT    = SLOT_DEF,
  parameter int unsigned BCK_DIV = BCK_DIV_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic                      o_bck,
  output logic                      o_lrck,
  output logic                      o_fall,
  output logic                      o_frame_wrap,
  output logic [$clog2(2*SLOT)-1:0] o_bit_nxt
);

  localparam int unsigned DW = $clog2(BCK_DIV);
  localparam int unsigned BW = $clog2(2*SLOT);

  localparam logic [DW-1:0] DIV_LAST = DW'(BCK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(BCK_DIV / 2);
  localparam logic [BW-1:0] BIT_LAST = BW'(2*SLOT - 1);
  localparam logic [BW-1:0] BIT_SLOT = BW'(SLOT);

  logic [DW-1:0] r_div_cnt;
  logic [DW-1:0] w_div_nxt;
  logic [BW-1:0] r_bit_cnt;
  logic [BW-1:0] w_bit_nxt;
  logic          r_bck;
  logic          r_lrck;
  logic          w_fall;
  logic          w_frame_wrap;

  always_comb begin
    w_fall       = (r_div_cnt == DIV_LAST);
    w_div_nxt    = w_fall ? '0 : r_div_cnt + 1'b1;
    w_frame_wrap = w_fall && (r_bit_cnt == BIT_LAST);
    w_bit_nxt    = r_bit_cnt;
    if (w_fall) begin
      w_bit_nxt = (r_bit_cnt == BIT_LAST) ? '0 : r_bit_cnt + 1'b1;
    end
  end

  // bck and lrck are registered from the next-state counters so they
  // line up with div_cnt/bit_cnt in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
      r_bck     <= 1'b0;
      r_lrck    <= 1'b0;
    end else begin
      r_div_cnt <= w_div_nxt;
      r_bit_cnt <= w_bit_nxt;
      r_bck     <= (w_div_nxt >= DIV_HALF);
      r_lrck    <= (w_bit_nxt >= BIT_SLOT);
    end
  end

  assign o_bck        = r_bck;
  assign o_lrck       = r_lrck;
  assign o_fall       = w_fall;
  assign o_frame_wrap = w_frame_wrap;
  assign o_bit_nxt    = w_bit_nxt;

endmodule

// File: rtl/i2s_tx.sv
// i2s_tx: I2S (Philips) master transmitter with a one-pair holding buffer.
//   clk, reset          : system clock, synchronous active-low reset
//   in_valid/in_ready   : sample pair handshake
//   in_left, in_right   : WIDTH-bit two's-complement samples
//   bck, lrck, dout     : registered I2S bit clock, word select, data
//   frame_start         : one-clk pulse when a new frame begins
//   underflow           : one-clk pulse when a frame begins with no pair held
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int unsigned WIDTH   = WIDTH_DEF,
  parameter int unsigned SLOT    = SLOT_DEF,
  parameter int unsigned BCK_DIV = BCK_DIV_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_left,
  input  logic [WIDTH-1:0] in_right,
  output logic             in_ready,
  output logic             bck,
  output logic             lrck,
  output logic             dout,
  output logic             frame_start,
  output logic             underflow
);

  localparam int unsigned BW = $clog2(2*SLOT);
  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [BW-1:0] SLOT_B  = BW'(SLOT);
  localparam logic [BW-1:0] WIDTH_B = BW'(WIDTH);

  logic             w_fall;
  logic             w_frame_wrap;
  logic [BW-1:0]    w_bit_nxt;
  logic [BW-1:0]    w_pos;
  logic [IW-1:0]    w_idx;
  logic [WIDTH-1:0] w_word;
  logic             w_dbit;
  logic             w_load;
  logic             w_accept;

  logic             r_hold_full;
  logic [WIDTH-1:0] r_hold_l;
  logic [WIDTH-1:0] r_hold_r;
  logic [WIDTH-1:0] r_frm_l;
  logic [WIDTH-1:0] r_frm_r;
  logic             r_dout;
  logic             r_frame_start;
  logic             r_underflow;

  i2s_clkgen #(
    .SLOT    (SLOT),
    .BCK_DIV (BCK_DIV)
  ) u_clkgen (
    .clk          (clk),
    .reset        (reset),
    .o_bck        (bck),
    .o_lrck       (lrck),
    .o_fall       (w_fall),
    .o_frame_wrap (w_frame_wrap),
    .o_bit_nxt    (w_bit_nxt)
  );

  always_comb begin
    w_load   = w_frame_wrap & r_hold_full;
    in_ready = reset & (~r_hold_full | w_load);
    w_accept = in_valid & in_ready;
    // Slot position and channel of the bit that goes out at the coming
    // falling edge; position 0 is the one-bck I2S delay, so it is padding.
    w_pos    = (w_bit_nxt >= SLOT_B) ? w_bit_nxt - SLOT_B : w_bit_nxt;
    w_word   = (w_bit_nxt >= SLOT_B) ? r_frm_r : r_frm_l;
    w_idx    = IW'(WIDTH_B - w_pos);
    w_dbit   = 1'b0;
    if ((w_pos != '0) && (w_pos <= WIDTH_B)) begin
      w_dbit = w_word[w_idx];
    end
  end

  // At a frame wrap the next position is 0, so dout is padding on that edge
  // and the frame register may be reloaded in the same edge without hazard.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hold_full   <= 1'b0;
      r_hold_l      <= '0;
      r_hold_r      <= '0;
      r_frm_l       <= '0;
      r_frm_r       <= '0;
      r_dout        <= 1'b0;
      r_frame_start <= 1'b0;
      r_underflow   <= 1'b0;
    end else begin
      r_frame_start <= w_frame_wrap;
      r_underflow   <= w_frame_wrap & ~r_hold_full;
      if (w_frame_wrap) begin
        r_frm_l <= w_load ? r_hold_l : '0;
        r_frm_r <= w_load ? r_hold_r : '0;
      end
      if (w_accept) begin
        r_hold_l    <= in_left;
        r_hold_r    <= in_right;
        r_hold_full <= 1'b1;
      end else if (w_load) begin
        r_hold_full <= 1'b0;
      end
      if (w_fall) begin
        r_dout <= w_dbit;
      end
    end
  end

  assign dout        = r_dout;
  assign frame_start = r_frame_start;
  assign underflow   = r_underflow;

endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: self-checking bench for i2s_tx.
// The reference model tracks time since reset release and derives every
// expected output from it with plain arithmetic; accepted pairs go through
// a queue standing in for the holding buffer. A bench-side I2S deserialiser
// recovers each slot word from bck/lrck/dout and compares it to the frame
// contents the model expects.
module tb_i2s_tx;
  import i2s_pkg::*;

  localparam int WIDTH   = 24;
  localparam int SLOT    = 32;
  localparam int BCK_DIV = 4;
  localparam int FRAME   = 2 * SLOT * BCK_DIV;

  logic             clk      = 1'b0;
  logic             reset    = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_left  = '0;
  logic [WIDTH-1:0] in_right = '0;
  logic             in_ready;
  logic             bck;
  logic             lrck;
  logic             dout;
  logic             frame_start;
  logic             underflow;

  i2s_tx #(
    .WIDTH   (WIDTH),
    .SLOT    (SLOT),
    .BCK_DIV (BCK_DIV)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_left     (in_left),
    .in_right    (in_right),
    .in_ready    (in_ready),
    .bck         (bck),
    .lrck        (lrck),
    .dout        (dout),
    .frame_start (frame_start),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  // reference model state
  int      t;            // clk edges since reset release
  stereo_t hold_q[$];    // pairs accepted but not yet framed
  stereo_t frm;          // pair being transmitted in the current frame
  bit      fs_e;
  bit      uf_e;
  bit      acc;          // model: a transfer happened at the last edge

  // deserialiser state
  bit             des_prev_bck;
  bit             des_lr;
  int             des_pos;
  logic [WIDTH-1:0] des_word;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0d)", tag, got, exp, t);
    end
  endtask

  function automatic logic exp_dout(input int tt);
    int               b;
    int               p;
    logic [WIDTH-1:0] w;
    logic [WIDTH-1:0] s;
    b = (tt / BCK_DIV) % (2 * SLOT);
    p = b % SLOT;
    w = (b >= SLOT) ? frm.right : frm.left;
    if (p >= 1 && p <= WIDTH) begin
      s = w >> (WIDTH - p);
      return s[0];
    end
    return 1'b0;
  endfunction

  // One clk cycle: entered at a negedge with inputs already driven.
  task automatic tick();
    bit rdy_e;
    #1;
    rdy_e = reset && (hold_q.size() == 0 || ((t + 1) % FRAME == 0));
    check("in_ready", in_ready, rdy_e);
    acc = rdy_e && in_valid;
    @(posedge clk);
    if (!reset) begin
      t = 0;
      hold_q.delete();
      frm  = '0;
      fs_e = 1'b0;
      uf_e = 1'b0;
      acc  = 1'b0;
      des_prev_bck = 1'b0;
      des_lr       = 1'b1;
      des_pos      = 0;
      des_word     = '0;
    end else begin
      t++;
      fs_e = 1'b0;
      uf_e = 1'b0;
      if (t % FRAME == 0) begin
        fs_e = 1'b1;
        if (hold_q.size() != 0) begin
          frm = hold_q.pop_front();
        end else begin
          frm  = '0;
          uf_e = 1'b1;
        end
      end
      if (acc) hold_q.push_back('{left: in_left, right: in_right});
    end
    @(negedge clk);
    check("bck",         bck,         ((t % BCK_DIV) >= BCK_DIV / 2));
    check("lrck",        lrck,        (((t / BCK_DIV) % (2 * SLOT)) >= SLOT));
    check("dout",        dout,        exp_dout(t));
    check("frame_start", frame_start, fs_e);
    check("underflow",   underflow,   uf_e);
    if (reset) begin
      if (bck && !des_prev_bck) begin
        if (lrck != des_lr) begin
          des_lr  = lrck;
          des_pos = 0;
        end else begin
          des_pos++;
        end
        if (des_pos >= 1 && des_pos <= WIDTH) des_word = {des_word[WIDTH-2:0], dout};
        if (des_pos == WIDTH)
          check(lrck ? "deser_right" : "deser_left", des_word, lrck ? frm.right : frm.left);
      end
      des_prev_bck = bck;
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  initial begin
    t = 0;
    @(negedge clk);

    // reset held for a few cycles
    reset = 1'b0;
    run(3);
    reset = 1'b1;

    // single pair right after release; then starve through an underflow
    in_valid = 1'b1;
    in_left  = 24'hA5A5A5;
    in_right = 24'h5A5A5A;
    tick();
    in_valid = 1'b0;
    in_left  = 24'h123456;
    in_right = 24'h654321;
    run(3 * FRAME);

    // continuous valid with incrementing pairs
    in_valid = 1'b1;
    in_left  = 24'h000100;
    in_right = 24'h800100;
    for (int i = 0; i < 4 * FRAME; i++) begin
      tick();
      if (acc) begin
        in_left  = in_left + 1'b1;
        in_right = in_right + 1'b1;
      end
    end
    in_valid = 1'b0;

    // full-scale negative left sample
    in_valid = 1'b1;
    in_left  = 24'h800000;
    in_right = WIDTH'($urandom);
    for (int i = 0; i < FRAME + 4; i++) begin
      tick();
      if (acc) break;
    end
    in_valid = 1'b0;
    run(2 * FRAME);

    // random sparse traffic; data lines toggle every cycle
    for (int i = 0; i < 6 * FRAME; i++) begin
      in_valid = ($urandom_range(0, 199) == 0);
      in_left  = WIDTH'($urandom);
      in_right = WIDTH'($urandom);
      tick();
    end
    in_valid = 1'b0;

    // reset at bit_cnt=40 with a pair sitting in the holding buffer
    for (int i = 0; i < 3 * FRAME; i++) begin
      if (hold_q.size() == 1 && (t % FRAME) == 40 * BCK_DIV) break;
      in_valid = (hold_q.size() == 0);
      in_left  = WIDTH'($urandom);
      in_right = WIDTH'($urandom);
      tick();
      in_valid = 1'b0;
    end
    check("hold_before_reset", hold_q.size(), 1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    run(FRAME + 16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
